// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier writing a 2*WIDTH product into hi/lo.
// Optional MULT_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             mf_read,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   state_t             state;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   mplier_next;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [CW-1:0]      count;
   logic               neg;
   logic               last;
   // Operand magnitudes, one shift-add step and the RUN exit condition.
   always_comb begin
      mag_a       = (mult_sign & operand_a[WIDTH-1]) ? -operand_a : operand_a;
      mag_b       = (mult_sign & operand_b[WIDTH-1]) ? -operand_b : operand_b;
      acc_next    = mplier[0] ? acc + mcand : acc;
      mplier_next = mplier >> 1;
`ifdef MULT_EARLY_TERM_EN
      last        = (count == CW'(1)) || (mplier_next == '0);
`else
      last        = (count == CW'(1));
`endif
   end
   // Control FSM; busy stays high through the done cycle so a held MFHI/MULT waits one more cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         neg    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_mult && !busy) begin
                  mcand  <= {{WIDTH{1'b0}}, mag_a};
                  mplier <= mag_b;
                  neg    <= mult_sign & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                  acc    <= '0;
                  count  <= CW'(WIDTH);
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  busy <= 1'b0;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mplier <= mplier_next;
               mcand  <= mcand << 1;
               count  <= count - CW'(1);
               state  <= last ? FINISH : RUN;
            end
            FINISH: begin
               {hi, lo} <= neg ? -acc : acc;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Hold the pipeline while a multiply owns hi/lo.
   always_comb stall = busy & (mf_read | start_mult);
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: vector table plus stall and mid-run reset sequences, checked through a product scoreboard.
module tb_mult_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_mult = 1'b0;
   logic        mult_sign = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        mf_read = 1'b0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;
   int          checks = 0;
   int          failures = 0;
   logic [63:0] q[$];
   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[14];

   mult_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start_mult(start_mult), .mult_sign(mult_sign),
      .operand_a(operand_a), .operand_b(operand_b), .mf_read(mf_read),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pop_cmp(string nm);
      logic [63:0] e;
      if (q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: done with empty scoreboard, got %h", nm, {hi, lo});
      end else begin
         e = q.pop_front();
         chk(nm, {hi, lo}, e);
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!done && cyc < 200);
      chk("done_seen", {63'b0, done}, 64'd1);
   endtask

   function automatic logic [63:0] model(logic s, logic [31:0] a, logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = s ? {{32{a[31]}}, a} : {32'b0, a};
      eb = s ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   function automatic int exp_lat(logic s, logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
      logic [31:0] m;
      int k;
      m = (s && b[31]) ? -b : b;
      k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i;
      return k + 2;
`else
      return (s | b[0]) ? 33 : 33;
`endif
   endfunction

   initial begin
      int cyc;
      int n;
      logic seen;
      logic [63:0] prev;
      vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
      vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
      vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
      vecs[3]  = '{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
      vecs[4]  = '{1'b1, 32'h80000000, 32'h00000002, 64'hFFFFFFFF_00000000};
      vecs[5]  = '{1'b0, 32'hFFFFFFFD, 32'h00000007, 64'h00000006_FFFFFFEB};
      vecs[6]  = '{1'b0, 32'd1234,     32'd1,        64'd1234};
      vecs[7]  = '{1'b0, 32'd5,        32'd0,        64'd0};
      vecs[8]  = '{1'b1, 32'h00000007, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFF9};
      vecs[9]  = '{1'b1, 32'hFFFF0000, 32'h00010000, 64'hFFFFFFFF_00000000};
      for (int i = 10; i < 14; i++) begin
         vecs[i].sgn = 1'($urandom_range(0, 1));
         vecs[i].a   = $urandom;
         vecs[i].b   = $urandom;
         vecs[i].exp = model(vecs[i].sgn, vecs[i].a, vecs[i].b);
      end
      // reset state, with requests present so a busy flag would show on stall
      start_mult = 1'b1;
      mf_read    = 1'b1;
      tick();
      tick();
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_stall", {63'b0, stall}, 64'd0);
      start_mult = 1'b0;
      mf_read    = 1'b0;
      #2 rst = 1'b0;
      tick();
      prev = '0;
      // table-driven products
      foreach (vecs[i]) begin
         mult_sign  = vecs[i].sgn;
         operand_a  = vecs[i].a;
         operand_b  = vecs[i].b;
         start_mult = 1'b1;
         tick();
         q.push_back(vecs[i].exp);
         start_mult = 1'b0;
         chk($sformatf("hold[%0d]", i), {hi, lo}, prev);
         wait_done(cyc);
         chk($sformatf("latency[%0d]", i), 64'(cyc), 64'(exp_lat(vecs[i].sgn, vecs[i].b)));
         pop_cmp($sformatf("product[%0d]", i));
         prev = vecs[i].exp;
         tick();
         chk($sformatf("done_pulse[%0d]", i), {63'b0, done}, 64'd0);
         chk($sformatf("busy_clear[%0d]", i), {63'b0, busy}, 64'd0);
      end
      // stall window: MFHI from cycle 2, second MULTU held in execute from cycle 5
      mult_sign  = 1'b0;
      operand_a  = 32'd3;
      operand_b  = 32'd4;
      start_mult = 1'b1;
      tick();
      q.push_back(64'd12);
      start_mult = 1'b0;
      tick();
      mf_read = 1'b1;
      n = 2;
      seen = 1'b0;
      while (!seen && n < 200) begin
         if (n == 5) begin
            start_mult = 1'b1;
            operand_a  = 32'd7;
            operand_b  = 32'd8;
         end
         #1 chk($sformatf("stall_on[%0d]", n), {63'b0, stall}, 64'd1);
         seen = done;
         if (seen) begin
            chk("stall_lat", 64'(n), 64'(exp_lat(1'b0, 32'd4) + 1));
            pop_cmp("stall_first");
         end
         tick();
         n++;
      end
      chk("stall_done_seen", {63'b0, seen}, 64'd1);
      #1 chk("stall_off", {63'b0, stall}, 64'd0);
      q.push_back(64'd56);
      tick();
      start_mult = 1'b0;
      mf_read    = 1'b0;
      wait_done(cyc);
      chk("second_lat", 64'(cyc), 64'(exp_lat(1'b0, 32'd8)));
      pop_cmp("second_product");
      tick();
      // asynchronous reset in the middle of RUN
      mult_sign  = 1'b0;
      operand_a  = 32'hFFFFFFFF;
      operand_b  = 32'hFFFFFFFF;
      start_mult = 1'b1;
      tick();
      start_mult = 1'b0;
      mf_read    = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      chk("pre_rst_busy", {63'b0, busy}, 64'd1);
      #3 rst = 1'b1;
      #1;
      chk("async_hilo", {hi, lo}, 64'd0);
      chk("async_busy", {63'b0, busy}, 64'd0);
      chk("async_stall", {63'b0, stall}, 64'd0);
      #2 rst = 1'b0;
      mf_read = 1'b0;
      q.delete();
      tick();
      operand_a  = 32'd5;
      operand_b  = 32'd6;
      start_mult = 1'b1;
      tick();
      q.push_back(64'd30);
      start_mult = 1'b0;
      wait_done(cyc);
      chk("post_rst_lat", 64'(cyc), 64'(exp_lat(1'b0, 32'd6)));
      pop_cmp("post_rst_product");
      tick();
      chk("post_rst_done_pulse", {63'b0, done}, 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative shift-add multiplier sitting in the execute stage, directly downstream of the control unit.
- Consumes the control unit's start_mult and mult_sign outputs for MULT/MULTU.
- Produces the 64-bit product into HI/LO registers, which the out_select mux reads for MFHI/MFLO.
- Raises a stall request while a multiply is in flight and the pipeline tries to read HI/LO or issue another multiply.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits, split into hi and lo.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start_mult  input  1  control unit request to begin a multiply.
- mult_sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start_mult.
- operand_a  input  WIDTH  rs value; sampled with start_mult.
- operand_b  input  WIDTH  rt value; sampled with start_mult.
- mf_read  input  1  decode of MFHI/MFLO in the current execute instruction.
- hi  output  WIDTH  upper half of the last completed product.
- lo  output  WIDTH  lower half of the last completed product.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse when hi/lo update.
- stall  output  1  pipeline hold request.

Behaviour:
- Reset (async, active-high) forces state=IDLE and hi=lo=0, busy=0, done=0, stall=0. This takes effect immediately, including mid-RUN, and the partial product is discarded.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On a rising edge with start_mult=1, latch |a| and |b| into the multiplicand and multiplier registers.
  - |x| applies the two's-complement negate only when mult_sign=1 and the MSB is 1. Unsigned operands are used raw.
  - Latch neg = mult_sign & (a[WIDTH-1] ^ b[WIDTH-1]). Clear the 2*WIDTH accumulator, load count=WIDTH, go to RUN.
- RUN, each edge:
  - If multiplier[0], acc += multiplicand shifted left by (WIDTH-count).
  - Shift multiplier right by 1 and decrement count.
  - When count reaches 0, go to FINISH.
- FINISH, one edge:
  - hi:lo <= neg ? -acc : acc (2*WIDTH-bit two's complement).
  - done=1 for this cycle only; return to IDLE.
- Latency: start sampled at edge 0; hi/lo valid and done=1 after edge WIDTH+1, i.e. 33 cycles at WIDTH=32.
- busy=1 in RUN and FINISH, 0 in IDLE. It is registered from the state.
- hi/lo hold their previous values throughout RUN/FINISH until the FINISH edge.
- stall = busy & (mf_read | start_mult), combinational. It deasserts in the cycle after done, so MFHI held in execute reads the new hi.
- start_mult while busy: ignored, with stall=1 holding the instruction in execute. It is accepted on the first IDLE edge.
- start_mult and done in the same cycle: the new multiply is not accepted until IDLE (stall=1 that cycle).
- The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned WIDTH bits; no overflow case exists.

Optional Feature:
- MULT_EARLY_TERM_EN
- Defined: RUN also exits to FINISH when the shifted multiplier register equals 0. Latency becomes (index of highest set bit of |b|)+2 cycles, minimum 2 for b=0 or b=1. Results are identical.
- Undefined: RUN is always exactly WIDTH cycles, fixed latency WIDTH+1.

Test Plan:
- Unsigned 0xFFFFFFFF*0xFFFFFFFF, mult_sign=0 -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses exactly one cycle, busy=0 the next cycle.
- Signed -3 (0xFFFFFFFD) * 7, mult_sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
- Operands 0x80000000*0x00000002 -> with mult_sign=0: hi=0x00000001, lo=0; with mult_sign=1: hi=0xFFFFFFFF, lo=0x00000000.
- mf_read=1 from cycle 2 of a multiply -> stall=1 through the done cycle, 0 afterwards. Second start_mult at cycle 5 -> stall=1, ignored; it starts after IDLE and hi/lo reflect the second product 33 cycles later.
- rst pulsed at cycle 10 of RUN -> hi=lo=0, busy=0, stall=0 without waiting for clk. A subsequent 5*6 unsigned multiply yields hi=0, lo=30.
- With MULT_EARLY_TERM_EN: 1234*1 -> done after 2 cycles, lo=1234. 5*0 -> done after 2 cycles, hi=lo=0. Without the macro the same stimulus takes 33 cycles with identical results.
